// File: rtl/ps2_tx_bank.sv
// Multi-channel PS/2 device-side transmitter: per-channel byte FIFO feeding an
// 11-bit frame serialiser on a shared divided clock phase. Optional host-inhibit
// support is enabled with the PS2_TX_INHIBIT_EN macro.
module ps2_tx_bank #(
  parameter int unsigned CHANNELS  = 2,
  parameter int unsigned FIFO_BITS = 3,
  parameter int unsigned PS2DIV    = 100,
  parameter int unsigned CH_BITS   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk_sys,
  input  logic                reset_n,
  input  logic                wr_strobe,
  input  logic [CH_BITS-1:0]  wr_chan,
  input  logic [7:0]          wr_data,
  input  logic [CHANNELS-1:0] ovf_clr,
  input  logic [CHANNELS-1:0] ps2_clk_in,
  output logic [CHANNELS-1:0] ps2_clk,
  output logic [CHANNELS-1:0] ps2_data,
  output logic [CHANNELS-1:0] fifo_empty,
  output logic [CHANNELS-1:0] busy,
  output logic [CHANNELS-1:0] overflow
);

  localparam int unsigned CNT_W = $clog2(PS2DIV);
  localparam int unsigned PTR_W = FIFO_BITS + 1;
  localparam int unsigned DEPTH = 1 << FIFO_BITS;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(PS2DIV - 1);

  localparam logic [3:0] ST_IDLE = 4'd0;
  localparam logic [3:0] ST_PAR  = 4'd9;
  localparam logic [3:0] ST_STOP = 4'd10;
  localparam logic [3:0] ST_END  = 4'd11;

  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                ph_q, ph_d;
  logic                rise;
  logic [CHANNELS-1:0] line_low;

  // Shared half-period divider; rise marks the ph 0->1 transition
  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    ph_d  = ph_q;
    if (cnt_q == CNT_MAX) begin
      cnt_d = '0;
      ph_d  = ~ph_q;
    end
  end

  assign rise = (cnt_q == CNT_MAX) && !ph_q;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
      ph_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ph_q  <= ph_d;
    end
  end

`ifdef PS2_TX_INHIBIT_EN
  logic [CHANNELS-1:0] sync1_q, sync2_q;

  // Host clock line is asynchronous; idle level is high
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= ps2_clk_in;
      sync2_q <= sync1_q;
    end
  end

  assign line_low = ~sync2_q;
`else
  logic unused_clk_in;
  assign unused_clk_in = ^ps2_clk_in;
  assign line_low      = '0;
`endif

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [3:0]       state_q, state_d;
    logic [7:0]       shift_q, shift_d;
    logic             parity_q, parity_d;
    logic             data_q, data_d;
    logic             ovf_q, ovf_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [7:0]       mem_q [DEPTH];
    logic             wr_hit, full, empty, push, pop, abort, start;

    assign wr_hit = wr_strobe && (wr_chan == CH_BITS'(c));
    assign empty  = (wr_ptr_q == rd_ptr_q);
    assign full   = (wr_ptr_q[FIFO_BITS] != rd_ptr_q[FIFO_BITS]) &&
                    (wr_ptr_q[FIFO_BITS-1:0] == rd_ptr_q[FIFO_BITS-1:0]);
    assign push   = wr_hit && !full;
    assign abort  = rise && line_low[c] && (state_q != ST_IDLE);
    assign start  = rise && (state_q == ST_IDLE) && !empty && !line_low[c];

    always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
        state_q  <= ST_IDLE;
        shift_q  <= '0;
        parity_q <= 1'b0;
        data_q   <= 1'b1;
        ovf_q    <= 1'b0;
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        state_q  <= state_d;
        shift_q  <= shift_d;
        parity_q <= parity_d;
        data_q   <= data_d;
        ovf_q    <= ovf_d;
        wr_ptr_q <= wr_ptr_d;
        rd_ptr_q <= rd_ptr_d;
      end
    end

    always_comb begin
      state_d = state_q;
      if (abort) begin
        state_d = ST_IDLE;
      end else if (rise) begin
        case (state_q)
          ST_IDLE: if (start) state_d = 4'd1;
          ST_END:  state_d = ST_IDLE;
          default: state_d = state_q + 4'd1;
        endcase
      end
    end

    // Line value and shift/parity updates; the head byte is popped only after the stop bit
    always_comb begin
      shift_d  = shift_q;
      parity_d = parity_q;
      data_d   = data_q;
      pop      = 1'b0;
      if (abort) begin
        data_d = 1'b1;
      end else if (rise) begin
        case (state_q)
          ST_IDLE: begin
            if (start) begin
              shift_d  = mem_q[rd_ptr_q[FIFO_BITS-1:0]];
              parity_d = 1'b1;
              data_d   = 1'b0;
            end
          end
          4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8: begin
            data_d   = shift_q[0];
            shift_d  = {1'b0, shift_q[7:1]};
            parity_d = parity_q ^ shift_q[0];
          end
          ST_PAR:  data_d = parity_q;
          ST_STOP: data_d = 1'b1;
          ST_END:  pop = 1'b1;
          default: data_d = 1'b1;
        endcase
      end
    end

    always_comb begin
      wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
      ovf_d    = ovf_q;
      if (wr_hit && full)   ovf_d = 1'b1;
      else if (ovf_clr[c])  ovf_d = 1'b0;
    end

    always_ff @(posedge clk_sys) begin
      if (push) mem_q[wr_ptr_q[FIFO_BITS-1:0]] <= wr_data;
    end

    assign ps2_clk[c]    = ph_q | (state_q == ST_IDLE);
    assign ps2_data[c]   = data_q;
    assign fifo_empty[c] = empty;
    assign busy[c]       = (state_q != ST_IDLE);
    assign overflow[c]   = ovf_q;
  end

endmodule

// File: tb/tb_ps2_tx_bank.sv
// Randomised bench for ps2_tx_bank: a timeline model (queues plus frame-start
// bookkeeping) predicts every output on every cycle.
module tb_ps2_tx_bank;
  localparam int NCH   = 3;
  localparam int FB    = 3;
  localparam int DIV   = 4;
  localparam int DEPTH = 8;
  localparam int PER   = 2 * DIV;
  localparam int FRAME = 22 * DIV;

  logic           clk_sys = 1'b0;
  logic           reset_n = 1'b1;
  logic           wr_strobe = 1'b0;
  logic [1:0]     wr_chan = '0;
  logic [7:0]     wr_data = '0;
  logic [NCH-1:0] ovf_clr = '0;
  logic [NCH-1:0] ps2_clk_in = '1;
  logic [NCH-1:0] ps2_clk, ps2_data, fifo_empty, busy, overflow;

  always #5 clk_sys = ~clk_sys;

  ps2_tx_bank #(.CHANNELS(NCH), .FIFO_BITS(FB), .PS2DIV(DIV)) dut (
    .clk_sys   (clk_sys),
    .reset_n   (reset_n),
    .wr_strobe (wr_strobe),
    .wr_chan   (wr_chan),
    .wr_data   (wr_data),
    .ovf_clr   (ovf_clr),
    .ps2_clk_in(ps2_clk_in),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .fifo_empty(fifo_empty),
    .busy      (busy),
    .overflow  (overflow)
  );

  logic [7:0] mq [NCH][$];
  bit         act [NCH];
  int         st [NCH];
  logic [7:0] cur [NCH];
  bit         ovf_m [NCH];
  int         e;
  int         n_chk = 0;
  int         n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
  endtask

  // Frame bit j: start, eight data bits LSB first, odd parity, stop
  function automatic logic fbit(input logic [7:0] b, input int j);
    if (j == 0) return 1'b0;
    if (j <= 8) return b[j-1];
    if (j == 9) return ~^b;
    return 1'b1;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      mq[c].delete();
      act[c]   = 1'b0;
      ovf_m[c] = 1'b0;
    end
    e = 0;
  endtask

  task automatic model_edge();
    bit rise, full;
    e++;
    rise = (e % PER) == DIV;
    for (int c = 0; c < NCH; c++) begin
      full = (mq[c].size() == DEPTH);
      if (rise) begin
        if (act[c] && e == st[c] + FRAME) begin
          void'(mq[c].pop_front());
          act[c] = 1'b0;
        end else if (!act[c] && mq[c].size() != 0) begin
          act[c] = 1'b1;
          st[c]  = e;
          cur[c] = mq[c][0];
        end
      end
      if (wr_strobe && int'(wr_chan) == c && !full) mq[c].push_back(wr_data);
      if (wr_strobe && int'(wr_chan) == c && full) ovf_m[c] = 1'b1;
      else if (ovf_clr[c]) ovf_m[c] = 1'b0;
    end
  endtask

  task automatic check_out();
    logic [NCH-1:0] x_clk, x_data, x_empty, x_busy, x_ovf;
    bit ph;
    ph = ((e / DIV) % 2) == 1;
    for (int c = 0; c < NCH; c++) begin
      x_busy[c]  = act[c];
      x_clk[c]   = ph | !act[c];
      x_data[c]  = act[c] ? fbit(cur[c], (e - st[c]) / PER) : 1'b1;
      x_empty[c] = (mq[c].size() == 0);
      x_ovf[c]   = ovf_m[c];
    end
    chk("ps2_clk",    32'(ps2_clk),    32'(x_clk));
    chk("ps2_data",   32'(ps2_data),   32'(x_data));
    chk("fifo_empty", 32'(fifo_empty), 32'(x_empty));
    chk("busy",       32'(busy),       32'(x_busy));
    chk("overflow",   32'(overflow),   32'(x_ovf));
  endtask

  task automatic tick();
    @(posedge clk_sys);
    model_edge();
    #1;
    check_out();
    wr_strobe = 1'b0;
    ovf_clr   = '0;
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic put(input int ch, input logic [7:0] d);
    wr_strobe = 1'b1;
    wr_chan   = 2'(ch);
    wr_data   = d;
    tick();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    model_reset();
    #1;
    check_out();
    repeat (2) @(posedge clk_sys);
    #1;
    check_out();
    @(negedge clk_sys);
    reset_n = 1'b1;
  endtask

  initial begin
    int found;
    #2;
    do_reset();

    // Single byte, then a burst that overruns ch1 and a later overflow clear
    put(0, 8'hA5);
    run(120);
    for (int i = 1; i <= 9; i++) put(1, 8'(i));
    run(300);
    ovf_clr = 3'b010;
    tick();
    run(800);

    // Concurrent channels, and a write to a channel that does not exist
    put(0, 8'h12);
    put(2, 8'h34);
    run(120);
    put(3, 8'hFF);
    run(4);

    // Reset while ch2 is driving its parity bit
    put(2, 8'h55);
    found = 0;
    for (int i = 0; i < 400; i++) begin
      if (act[2] && (e - st[2]) / PER == 9) begin
        found = 1;
        break;
      end
      tick();
    end
    chk("reach_parity", 32'(found), 32'd1);
    do_reset();
    run(200);

    // Random traffic including invalid channels, overflow clears and one reset
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        wr_strobe = 1'b1;
        wr_chan   = 2'($urandom_range(0, 3));
        wr_data   = 8'($urandom);
      end
      if ($urandom_range(0, 31) == 0) ovf_clr = 3'($urandom);
      if (i == 1500) do_reset();
      else tick();
    end
    run(1200);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
